// File: rtl/mem_access_if.sv
// mem_access_if: req/ack data bus between mem_access (master) and the memory (slave)
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access.sv
// mem_access: load/store responder driving a req/ack bus; byte/half stores use read-modify-write.
// Optional MEM_ALIGN_CHECK_EN: misaligned half/word accesses skip the bus and pulse misalign_o.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r_mem_enable_i,
    input  logic [31:0] r_mem_addr_i,
    input  logic        w_mem_enable_i,
    input  logic [31:0] w_mem_addr_i,
    input  logic [31:0] w_mem_data_i,
    input  logic [2:0]  data_type_i,
    input  logic [4:0]  w_reg_addr_i,
    output logic        stall_o,
    output logic        load_valid_o,
    output logic [4:0]  load_addr_o,
    output logic [31:0] load_data_o,
    output logic        bus_err_o,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    mem_access_if.master bus
);
    localparam logic [2:0] DT_NO    = 3'd0;
    localparam logic [2:0] DT_BYTE  = 3'd1;
    localparam logic [2:0] DT_HALF  = 3'd2;
    localparam logic [2:0] DT_UBYTE = 3'd4;
    localparam logic [2:0] DT_UHALF = 3'd5;
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE} state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        store_q;
    logic [2:0]  type_q;
    logic [1:0]  lane_q;
    logic [15:0] sdata_q;
    logic [31:0] rdata_q;
    logic [4:0]  reg_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic        load_valid_q;
    logic [4:0]  load_addr_q;
    logic [31:0] load_data_q;
    logic        bus_err_q;

    logic        req_d;
    logic [31:0] addr_d;
    logic        sub_word_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [31:0] load_ext_d;
    logic        byte_sel_d;
    logic [31:0] lane_mask_d;
    logic [31:0] merged_d;

    // A store wins over a load when both enables are high
    assign req_d      = (w_mem_enable_i | r_mem_enable_i) && (data_type_i != DT_NO);
    assign addr_d     = w_mem_enable_i ? w_mem_addr_i : r_mem_addr_i;
    assign sub_word_d = data_type_i == DT_BYTE || data_type_i == DT_HALF ||
                        data_type_i == DT_UBYTE || data_type_i == DT_UHALF;

    // Lane extraction and extension of the word returned by the bus
    assign byte_d     = 8'(bus.rdata >> {lane_q, 3'b000});
    assign half_d     = lane_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
    assign load_ext_d = type_q == DT_BYTE  ? {{24{byte_d[7]}}, byte_d} :
                        type_q == DT_UBYTE ? {24'd0, byte_d} :
                        type_q == DT_HALF  ? {{16{half_d[15]}}, half_d} :
                        type_q == DT_UHALF ? {16'd0, half_d} : bus.rdata;

    // Replace the addressed lane(s) of the captured word with the store data
    assign byte_sel_d  = type_q == DT_BYTE || type_q == DT_UBYTE;
    assign lane_mask_d = byte_sel_d ? (32'h0000_00FF << {lane_q, 3'b000}) :
                         (lane_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF);
    assign merged_d    = (rdata_q & ~lane_mask_d) |
                         ((byte_sel_d ? {4{sdata_q[7:0]}} : {2{sdata_q}}) & lane_mask_d);

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_d;
    logic misalign_q;
    assign misalign_d = ((data_type_i == DT_HALF || data_type_i == DT_UHALF) && addr_d[0]) ||
                        (!sub_word_d && addr_d[1:0] != 2'b00);
    assign misalign_o = misalign_q;
`endif

    assign stall_o      = (state_q == IDLE && req_d) || state_q == RD || state_q == MERGE || state_q == WR;
    assign load_valid_o = load_valid_q;
    assign load_addr_o  = load_addr_q;
    assign load_data_o  = load_data_q;
    assign bus_err_o    = bus_err_q;
    assign bus.req      = bus_req_q;
    assign bus.we       = bus_we_q;
    assign bus.addr     = bus_addr_q;
    assign bus.wdata    = bus_wdata_q;

    // Access sequencer: all bus and result outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            store_q      <= 1'b0;
            type_q       <= '0;
            lane_q       <= '0;
            sdata_q      <= '0;
            rdata_q      <= '0;
            reg_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            load_valid_q <= 1'b0;
            load_addr_q  <= '0;
            load_data_q  <= '0;
            bus_err_q    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: if (req_d) begin
                    store_q     <= w_mem_enable_i;
                    type_q      <= data_type_i;
                    lane_q      <= addr_d[1:0];
                    sdata_q     <= w_mem_data_i[15:0];
                    reg_q       <= w_reg_addr_i;
                    bus_addr_q  <= {addr_d[31:2], 2'b00};
                    bus_wdata_q <= w_mem_data_i;
                    cnt_q       <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                    if (misalign_d) begin
                        misalign_q <= 1'b1;
                        state_q    <= DONE;
                    end else
`endif
                    begin
                        bus_req_q <= 1'b1;
                        bus_we_q  <= w_mem_enable_i && !sub_word_d;
                        state_q   <= (w_mem_enable_i && !sub_word_d) ? WR : RD;
                    end
                end
                RD: if (bus.ack) begin
                    bus_req_q <= 1'b0;
                    rdata_q   <= bus.rdata;
                    if (store_q) begin
                        state_q <= MERGE;
                    end else begin
                        load_valid_q <= 1'b1;
                        load_addr_q  <= reg_q;
                        load_data_q  <= load_ext_d;
                        state_q      <= DONE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    bus_req_q <= 1'b0;
                    bus_err_q <= 1'b1;
                    state_q   <= DONE;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
                MERGE: begin
                    bus_wdata_q <= merged_d;
                    bus_req_q   <= 1'b1;
                    bus_we_q    <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= WR;
                end
                WR: if (bus.ack) begin
                    bus_req_q <= 1'b0;
                    state_q   <= DONE;
                end else if (cnt_q == TO_LAST) begin
                    bus_req_q <= 1'b0;
                    bus_err_q <= 1'b1;
                    state_q   <= DONE;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized load/store traffic against a cycle-timeline model of mem_access
module tb_mem_access;
    localparam int TO = 4;
    localparam logic [2:0] DT_NO = 3'd0, DT_BYTE = 3'd1, DT_HALF = 3'd2, DT_WORD = 3'd3;
    localparam logic [2:0] DT_UBYTE = 3'd4, DT_UHALF = 3'd5;

    typedef struct {
        logic        stall, req, we, lv, err, mis;
        logic [31:0] addr, wdata, ldata;
        logic [4:0]  laddr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r_en, w_en;
    logic [31:0] r_addr, w_addr, w_data;
    logic [2:0]  dtype;
    logic [4:0]  wreg;
    logic        stall, lv, berr;
    logic [4:0]  laddr;
    logic [31:0] ldata;
`ifdef MEM_ALIGN_CHECK_EN
    logic        mis;
`endif

    mem_access_if bus ();

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .r_mem_enable_i(r_en), .r_mem_addr_i(r_addr),
        .w_mem_enable_i(w_en), .w_mem_addr_i(w_addr), .w_mem_data_i(w_data),
        .data_type_i(dtype), .w_reg_addr_i(wreg),
        .stall_o(stall), .load_valid_o(lv), .load_addr_o(laddr), .load_data_o(ldata),
        .bus_err_o(berr),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_o(mis),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [logic [31:0]];
    exp_t        exp_q [$];
    int          plan_q [$];
    int          checks = 0, errors = 0;
    int          n_stall = 0, n_lv = 0, n_err = 0, n_req = 0, n_rd = 0, n_wr = 0, n_mis = 0;
    logic [31:0] last_ld = '0, last_wa = '0, last_wd = '0;

    function automatic logic [31:0] rd_mem(logic [31:0] a);
        return mem.exists(a) ? mem[a] : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    function automatic logic [31:0] m_ext(logic [31:0] w, logic [2:0] t, logic [31:0] a);
        logic [7:0]  by [4];
        logic [15:0] h;
        for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
        h = {by[{a[1], 1'b1}], by[{a[1], 1'b0}]};
        case (t)
            DT_BYTE:  return 32'($signed(by[a[1:0]]));
            DT_UBYTE: return {24'd0, by[a[1:0]]};
            DT_HALF:  return 32'($signed(h));
            DT_UHALF: return {16'd0, h};
            default:  return w;
        endcase
    endfunction

    function automatic logic [31:0] m_merge(logic [31:0] w, logic [31:0] d, logic [2:0] t, logic [31:0] a);
        logic [7:0] by [4];
        for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
        if (t == DT_BYTE || t == DT_UBYTE) by[a[1:0]] = d[7:0];
        else begin
            by[{a[1], 1'b0}] = d[7:0];
            by[{a[1], 1'b1}] = d[15:8];
        end
        return {by[3], by[2], by[1], by[0]};
    endfunction

    function automatic exp_t mk(logic s, logic rq, logic we, logic [31:0] a, logic [31:0] wd);
        exp_t e;
        e.stall = s; e.req = rq; e.we = we; e.addr = a; e.wdata = wd;
        e.lv = 1'b0; e.err = 1'b0; e.mis = 1'b0; e.ldata = '0; e.laddr = '0;
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // memory slave: per-phase ack delay from plan_q, stray acks while no request
    initial begin : slave
        int   wcnt, dly;
        logic prev;
        wcnt = 0; dly = 0; prev = 1'b0;
        bus.ack = 1'b0;
        bus.rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.req && !prev) begin
                dly = 0;
                if (plan_q.size() != 0) dly = plan_q.pop_front();
                wcnt = 0;
            end else if (bus.req) wcnt++;
            bus.ack = bus.req ? (wcnt == dly) : ($urandom_range(0, 3) == 0);
            bus.rdata = bus.req ? rd_mem(bus.addr) : $urandom;
            prev = bus.req;
        end
    end

    // one clock: sample at negedge, compare against the next timeline entry, return at posedge+2
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (stall) n_stall++;
        if (lv) begin n_lv++; last_ld = ldata; end
        if (berr) n_err++;
        if (bus.req) n_req++;
        if (bus.req && bus.ack) begin
            if (bus.we) begin n_wr++; last_wa = bus.addr; last_wd = bus.wdata; end
            else n_rd++;
        end
`ifdef MEM_ALIGN_CHECK_EN
        if (mis) n_mis++;
`endif
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("bus_req", 32'(bus.req), 32'(e.req));
            chk("load_valid", 32'(lv), 32'(e.lv));
            chk("bus_err", 32'(berr), 32'(e.err));
`ifdef MEM_ALIGN_CHECK_EN
            chk("misalign", 32'(mis), 32'(e.mis));
`endif
            if (e.req) begin
                chk("bus_we", 32'(bus.we), 32'(e.we));
                chk("bus_addr", bus.addr, e.addr);
            end
            if (e.req && e.we) chk("bus_wdata", bus.wdata, e.wdata);
            if (e.lv) begin
                chk("load_addr", 32'(laddr), 32'(e.laddr));
                chk("load_data", ldata, e.ldata);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            w_en = 1'b0; r_en = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                w_en = 1'($urandom_range(0, 1)); r_en = ~w_en;
                dtype = DT_NO;
            end else dtype = 3'($urandom_range(1, 5));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0));
            tick();
        end
    endtask

    // builds the expected cycle timeline of one access, then presents it for that many cycles
    task automatic run_op(logic st, logic [2:0] t, logic [31:0] a, logic [31:0] d, logic [4:0] r, int drd, int dwr);
        logic [31:0] wa, rw, w;
        logic        sub, mb, ab;
        exp_t        e;
        int          n;
        wa = {a[31:2], 2'b00};
        rw = rd_mem(wa);
        sub = (t != DT_WORD);
        w = sub ? m_merge(rw, d, t, a) : d;
        ab = 1'b0;
        mb = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mb = ((t == DT_HALF || t == DT_UHALF) && a[0]) || (t == DT_WORD && a[1:0] != 2'b00);
`endif
        w_en = st;
        r_en = st ? 1'($urandom_range(0, 1)) : 1'b1;
        w_addr = st ? a : $urandom;
        r_addr = st ? $urandom : a;
        w_data = d; dtype = t; wreg = r;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, '0, '0));
        if (mb) begin
            e = mk(1'b0, 1'b0, 1'b0, '0, '0);
            e.mis = 1'b1;
            exp_q.push_back(e);
        end else begin
            if (!st || sub) begin
                plan_q.push_back(drd);
                for (int i = 0; i < ((drd < TO) ? drd + 1 : TO); i++) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, wa, '0));
                ab = (drd >= TO);
            end
            if (st && !ab) begin
                if (sub) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, '0, '0));
                plan_q.push_back(dwr);
                for (int i = 0; i < ((dwr < TO) ? dwr + 1 : TO); i++) exp_q.push_back(mk(1'b1, 1'b1, 1'b1, wa, w));
                ab = (dwr >= TO);
            end
            e = mk(1'b0, 1'b0, 1'b0, '0, '0);
            e.err = ab;
            if (!st && !ab) begin
                e.lv = 1'b1; e.laddr = r; e.ldata = m_ext(rw, t, a);
            end
            exp_q.push_back(e);
        end
        n = exp_q.size();
        repeat (n) tick();
        if (st && !ab && !mb) mem[wa] = w;
        w_en = 1'b0; r_en = 1'b0; dtype = DT_NO;
    endtask

    initial begin : main
        int s0, s1, s2, s3;
        r_en = 1'b0; w_en = 1'b0; r_addr = '0; w_addr = '0; w_data = '0; dtype = DT_NO; wreg = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_bus_req", 32'(bus.req), 0);
        chk("rst_bus_we", 32'(bus.we), 0);
        chk("rst_bus_addr", bus.addr, 0);
        chk("rst_load_valid", 32'(lv), 0);
        chk("rst_load_data", ldata, 0);
        chk("rst_bus_err", 32'(berr), 0);
        rst_n = 1'b1;
        idle(2);

        mem[32'h100] = 32'h80FF_0000;
        s0 = n_stall; s1 = n_lv;
        run_op(1'b0, DT_BYTE, 32'h103, $urandom, 5'd7, 2, 0);
        chk("t1_load_data", last_ld, 32'hFFFF_FF80);
        chk("t1_stall_cycles", 32'(n_stall - s0), 4);
        chk("t1_valid_pulses", 32'(n_lv - s1), 1);
        idle(1);

        mem[32'h100] = 32'hBEEF_1234;
        s0 = n_stall;
        run_op(1'b0, DT_UHALF, 32'h102, $urandom, 5'd9, 0, 0);
        chk("t2_load_data", last_ld, 32'h0000_BEEF);
        chk("t2_stall_cycles", 32'(n_stall - s0), 2);

        mem[32'h200] = 32'h1122_3344;
        s0 = n_rd; s1 = n_wr;
        run_op(1'b1, DT_BYTE, 32'h201, 32'h0000_00AB, 5'd0, 0, 0);
        chk("t3_reads", 32'(n_rd - s0), 1);
        chk("t3_writes", 32'(n_wr - s1), 1);
        chk("t3_wr_addr", last_wa, 32'h200);
        chk("t3_wr_data", last_wd, 32'h1122_AB44);

        s0 = n_rd; s1 = n_wr; s2 = n_lv;
        run_op(1'b1, DT_WORD, 32'h40, 32'hDEAD_BEEF, 5'd3, 0, 0);
        chk("t4_reads", 32'(n_rd - s0), 0);
        chk("t4_writes", 32'(n_wr - s1), 1);
        chk("t4_wr_data", last_wd, 32'hDEAD_BEEF);
        chk("t4_no_valid", 32'(n_lv - s2), 0);

        s0 = n_err; s1 = n_lv; s2 = n_req;
        run_op(1'b0, DT_WORD, 32'h10, $urandom, 5'd4, TO, 0);
        chk("t5_err_pulses", 32'(n_err - s0), 1);
        chk("t5_no_valid", 32'(n_lv - s1), 0);
        chk("t5_req_cycles", 32'(n_req - s2), TO);
        idle(1);

`ifdef MEM_ALIGN_CHECK_EN
        s0 = n_mis; s1 = n_req;
        run_op(1'b0, DT_WORD, 32'h42, $urandom, 5'd5, 0, 0);
        chk("mis_pulses", 32'(n_mis - s0), 1);
        chk("mis_no_req", 32'(n_req - s1), 0);
`endif

        repeat (300) begin
            logic       st;
            logic [2:0] t;
            int         drd, dwr;
            st = 1'($urandom_range(0, 1));
            t = 3'($urandom_range(1, 5));
            drd = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, TO - 1);
            dwr = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, TO - 1);
            run_op(st, t, 32'($urandom_range(0, 63)), $urandom, 5'($urandom), drd, dwr);
            idle($urandom_range(0, 2));
        end

        plan_q.push_back(TO + 5);
        w_en = 1'b1; r_en = 1'b0; w_addr = 32'h201; w_data = 32'hCD; dtype = DT_BYTE;
        tick();
        chk("t6_req_in_rd", 32'(bus.req), 1);
        #1 rst_n = 1'b0;
        #1 chk("t6_req_async_drop", 32'(bus.req), 0);
        w_en = 1'b0; dtype = DT_NO;
        plan_q.delete();
        s0 = n_req; s3 = n_wr;
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("t6_no_req_after", 32'(n_req - s0), 0);
        chk("t6_no_write_after", 32'(n_wr - s3), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
